mips16_multicycle_ctrl: RTL

MIPS16_MULTICYCLE_CTRL -- requirements
Module: mips16_multicycle_ctrl

---
 rtl/mips16_multicycle_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mips16_multicycle_ctrl.sv
// mips16_multicycle_ctrl: Moore control FSM for a multicycle 16-bit MIPS-like datapath.
// Ports: clk, reset (sync, active-high); opcode = IR[15:13]; mem_ready = memory access done.
// Outputs: datapath strobes and muxes, alu_op, state (debug), instr_count (retired instructions).
// Define MIPS16_CTRL_MEM_WAIT_EN to make FETCH/MEM_RD/MEM_WR wait on mem_ready;
// otherwise mem_ready is ignored and every memory state lasts one cycle.
module mips16_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic        instr_done,
  output logic [1:0]  alu_op,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  pc_src,
  output logic [3:0]  state,
  output logic [15:0] instr_count
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3, MEM_ADDR = 4'd4, MEM_RD = 4'd5,
    MEM_WR = 4'd6, WB_MEM = 4'd7, WB_ALU = 4'd8, BRANCH = 4'd9, JUMP = 4'd10
  } state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [15:0] cnt_q, cnt_d;
  logic rdy;
`ifdef MIPS16_CTRL_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = mem_ready | 1'b1;
`endif
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    instr_done    = 1'b0;
    alu_op        = 2'b00;
    alu_src_b     = 2'b00;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    pc_src        = 2'b00;
    op_d          = op_q;
    state_d       = FETCH;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        ir_write  = rdy;
        pc_write  = rdy;
        state_d   = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 2'b11;
        op_d      = opcode;
        state_d   = opcode == 3'b000 ? EXEC_R :
                    (opcode == 3'b001 || opcode == 3'b111) ? EXEC_I :
                    opcode[2:1] == 2'b10 ? MEM_ADDR :
                    opcode == 3'b110 ? BRANCH : JUMP;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        state_d   = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = op_q == 3'b001 ? 2'b10 : 2'b11;
        state_d   = WB_ALU;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = op_q[0] ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = rdy ? WB_MEM : MEM_RD;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = rdy;
        state_d    = rdy ? FETCH : MEM_WR;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
      end
      WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = op_q == 3'b000 ? 2'b01 : 2'b00;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        reg_write  = op_q == 3'b011;
        reg_dst    = op_q == 3'b011 ? 2'b10 : 2'b00;
        mem_to_reg = op_q == 3'b011 ? 2'b10 : 2'b00;
        instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // Reset presents FETCH's datapath settings with every strobe held low.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      instr_done    = 1'b0;
      alu_op        = 2'b11;
      alu_src_b     = 2'b01;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      pc_src        = 2'b00;
    end
    cnt_d = cnt_q + {15'd0, instr_done};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= 3'b000;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end
  assign state       = reset ? 4'd0 : state_q;
  assign instr_count = cnt_q;
endmodule
